// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register: resolves WB->ID bypass and x0 operands, detects load-use
// hazards, inserts bubbles and counts them with a saturating counter.
module id_ex_operand_stage #(
    parameter int CTRL_W      = 8,
    parameter int MEMREAD_BIT = 0,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [31:0]       id_pc,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic [31:0]       id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [31:0]       rf_rd_data1,
    input  logic [31:0]       rf_rd_data2,
    input  logic              wb_reg_write,
    input  logic [4:0]        wb_rd,
    input  logic [31:0]       wb_data,
    input  logic              stall,
    input  logic              flush,
    output logic              hazard_stall,
    output logic              ex_valid,
    output logic [31:0]       ex_pc,
    output logic [31:0]       ex_imm,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [31:0]       ex_op1,
    output logic [31:0]       ex_op2,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // The RF writes on the same posedge it is read, so a matching WB write must bypass it.
    function automatic logic [31:0] resolve_operand(
        input logic [4:0]  rs,
        input logic [31:0] rf_data,
        input logic        wb_we,
        input logic [4:0]  wb_addr,
        input logic [31:0] wb_value
    );
        if (rs == 5'd0)
            return 32'd0;
        else if (wb_we && (wb_addr != 5'd0) && (wb_addr == rs))
            return wb_value;
        else
            return rf_data;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    logic              ex_valid_q, ex_valid_d;
    logic [31:0]       ex_pc_q,    ex_pc_d;
    logic [31:0]       ex_imm_q,   ex_imm_d;
    logic [4:0]        ex_rs1_q,   ex_rs1_d;
    logic [4:0]        ex_rs2_q,   ex_rs2_d;
    logic [4:0]        ex_rd_q,    ex_rd_d;
    logic [31:0]       ex_op1_q,   ex_op1_d;
    logic [31:0]       ex_op2_q,   ex_op2_d;
    logic [CTRL_W-1:0] ex_ctrl_q,  ex_ctrl_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;

    logic [31:0]       op1_res;
    logic [31:0]       op2_res;
    logic              hazard;

    always_comb begin
        op1_res = resolve_operand(id_rs1, rf_rd_data1, wb_reg_write, wb_rd, wb_data);
        op2_res = resolve_operand(id_rs2, rf_rd_data2, wb_reg_write, wb_rd, wb_data);
    end

    always_comb begin
        hazard = id_valid & ex_valid_q & ex_ctrl_q[MEMREAD_BIT] & (ex_rd_q != 5'd0)
               & ((ex_rd_q == id_rs1) | (ex_rd_q == id_rs2));
    end

    // Priority: flush > stall > load-use bubble > normal capture.
    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_pc_d    = ex_pc_q;
        ex_imm_d   = ex_imm_q;
        ex_rs1_d   = ex_rs1_q;
        ex_rs2_d   = ex_rs2_q;
        ex_rd_d    = ex_rd_q;
        ex_op1_d   = ex_op1_q;
        ex_op2_d   = ex_op2_q;
        ex_ctrl_d  = ex_ctrl_q;
        cnt_d      = cnt_q;
        if (flush) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = '0;
        end else if (!stall) begin
            if (hazard) begin
                ex_valid_d = 1'b0;
                ex_ctrl_d  = '0;
                cnt_d      = sat_inc(cnt_q);
            end else begin
                ex_valid_d = id_valid;
                ex_ctrl_d  = id_valid ? id_ctrl : '0;
                ex_pc_d    = id_pc;
                ex_imm_d   = id_imm;
                ex_rs1_d   = id_rs1;
                ex_rs2_d   = id_rs2;
                ex_rd_d    = id_rd;
                ex_op1_d   = op1_res;
                ex_op2_d   = op2_res;
            end
        end
    end

    // ID -> EX stage boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q <= 1'b0;
            ex_pc_q    <= '0;
            ex_imm_q   <= '0;
            ex_rs1_q   <= '0;
            ex_rs2_q   <= '0;
            ex_rd_q    <= '0;
            ex_op1_q   <= '0;
            ex_op2_q   <= '0;
            ex_ctrl_q  <= '0;
            cnt_q      <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_pc_q    <= ex_pc_d;
            ex_imm_q   <= ex_imm_d;
            ex_rs1_q   <= ex_rs1_d;
            ex_rs2_q   <= ex_rs2_d;
            ex_rd_q    <= ex_rd_d;
            ex_op1_q   <= ex_op1_d;
            ex_op2_q   <= ex_op2_d;
            ex_ctrl_q  <= ex_ctrl_d;
            cnt_q      <= cnt_d;
        end
    end

    assign hazard_stall = hazard;
    assign ex_valid     = ex_valid_q;
    assign ex_pc        = ex_pc_q;
    assign ex_imm       = ex_imm_q;
    assign ex_rs1       = ex_rs1_q;
    assign ex_rs2       = ex_rs2_q;
    assign ex_rd        = ex_rd_q;
    assign ex_op1       = ex_op1_q;
    assign ex_op2       = ex_op2_q;
    assign ex_ctrl      = ex_ctrl_q;
    assign bubble_cnt   = cnt_q;

endmodule
